// File: rtl/apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// apb_req_arbiter
// Two-requester round-robin arbiter driving a single APB master port.
// One transfer at a time: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
// Every output is registered (computed from the next state and captured on clk).
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset_b    : asynchronous active-low reset
//   req        : per-requester level request (bit i = requester i)
//   req_write  : per-requester direction (1 = write)
//   req_addr   : per-requester address, requester i at [i*PADDR_WL +: PADDR_WL]
//   req_wdata  : per-requester write data, requester i at [i*PDATA_WL +: PDATA_WL]
//   done       : one-cycle completion pulse to the granted requester
//   err        : high with done when the transfer timed out
//   rdata      : read data of the last successful read
//   busy       : high whenever the FSM is not in IDLE
//   psel/penable/pwrite/paddr/pwdata : APB request to the slave
//   pready/prdata                    : APB response from the slave
// -----------------------------------------------------------------------------
module apb_req_arbiter #(
  parameter int PADDR_WL = 4,
  parameter int PDATA_WL = 8,
  parameter int TIMEOUT  = 15
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic [1:0]            req,
  input  logic [1:0]            req_write,
  input  logic [2*PADDR_WL-1:0] req_addr,
  input  logic [2*PDATA_WL-1:0] req_wdata,
  output logic [1:0]            done,
  output logic                  err,
  output logic [PDATA_WL-1:0]   rdata,
  output logic                  busy,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [PADDR_WL-1:0]   paddr,
  output logic [PDATA_WL-1:0]   pwdata,
  input  logic                  pready,
  input  logic [PDATA_WL-1:0]   prdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Last wait-count value before the abort fires (counter starts at 0 in the
  // first ACCESS cycle, so TIMEOUT low cycles end when it reaches TIMEOUT-1).
  localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_gnt;
  logic                w_gnt_nxt;
  logic                r_last;
  logic                w_last_nxt;
  logic [7:0]          r_wait;
  logic [7:0]          w_wait_nxt;
  logic                w_sel;

  logic [1:0]          r_done;
  logic [1:0]          w_done_nxt;
  logic                r_err;
  logic                w_err_nxt;
  logic [PDATA_WL-1:0] r_rdata;
  logic [PDATA_WL-1:0] w_rdata_nxt;
  logic                r_busy;
  logic                w_busy_nxt;
  logic                r_psel;
  logic                w_psel_nxt;
  logic                r_penable;
  logic                w_penable_nxt;
  logic                r_pwrite;
  logic                w_pwrite_nxt;
  logic [PADDR_WL-1:0] r_paddr;
  logic [PADDR_WL-1:0] w_paddr_nxt;
  logic [PDATA_WL-1:0] r_pwdata;
  logic [PDATA_WL-1:0] w_pwdata_nxt;

  // Round-robin pick: on contention the requester not served last wins;
  // a lone requester wins outright (req[1] alone selects 1, otherwise 0).
  always_comb begin
    w_sel = 1'b0;
    if (req == 2'b11) begin
      w_sel = ~r_last;
    end else begin
      w_sel = req[1];
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_last_nxt    = r_last;
    w_wait_nxt    = r_wait;
    w_done_nxt    = 2'b00;
    w_err_nxt     = 1'b0;
    w_rdata_nxt   = r_rdata;
    w_psel_nxt    = 1'b0;
    w_penable_nxt = 1'b0;
    w_pwrite_nxt  = r_pwrite;
    w_paddr_nxt   = r_paddr;
    w_pwdata_nxt  = r_pwdata;

    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_nxt  = S_SETUP;
          w_gnt_nxt    = w_sel;
          w_psel_nxt   = 1'b1;
          w_pwrite_nxt = w_sel ? req_write[1] : req_write[0];
          w_paddr_nxt  = w_sel ? req_addr[2*PADDR_WL-1:PADDR_WL]
                               : req_addr[PADDR_WL-1:0];
          w_pwdata_nxt = w_sel ? req_wdata[2*PDATA_WL-1:PDATA_WL]
                               : req_wdata[PDATA_WL-1:0];
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SETUP: begin
        w_state_nxt   = S_ACCESS;
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b1;
        w_wait_nxt    = 8'd0;
      end
      S_ACCESS: begin
        if (pready) begin
          w_state_nxt = S_DONE;
          w_last_nxt  = r_gnt;
          w_done_nxt  = r_gnt ? 2'b10 : 2'b01;
          if (!r_pwrite) begin
            w_rdata_nxt = prdata;
          end else begin
            w_rdata_nxt = r_rdata;
          end
        end else if (r_wait == LP_WAIT_LAST) begin
          w_state_nxt = S_DONE;
          w_last_nxt  = r_gnt;
          w_done_nxt  = r_gnt ? 2'b10 : 2'b01;
          w_err_nxt   = 1'b1;
        end else begin
          w_wait_nxt    = r_wait + 8'd1;
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State, arbitration bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state   <= S_IDLE;
      r_gnt     <= 1'b0;
      r_last    <= 1'b1;
      r_wait    <= 8'd0;
      r_done    <= 2'b00;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_busy    <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_last    <= w_last_nxt;
      r_wait    <= w_wait_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_rdata   <= w_rdata_nxt;
      r_busy    <= w_busy_nxt;
      r_psel    <= w_psel_nxt;
      r_penable <= w_penable_nxt;
      r_pwrite  <= w_pwrite_nxt;
      r_paddr   <= w_paddr_nxt;
      r_pwdata  <= w_pwdata_nxt;
    end
  end

  assign done    = r_done;
  assign err     = r_err;
  assign rdata   = r_rdata;
  assign busy    = r_busy;
  assign psel    = r_psel;
  assign penable = r_penable;
  assign pwrite  = r_pwrite;
  assign paddr   = r_paddr;
  assign pwdata  = r_pwdata;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_req_arbiter
// Directed bench for apb_req_arbiter with a small APB slave model whose
// pready can be immediate, delayed by a fixed number of wait cycles, or tied low.
// -----------------------------------------------------------------------------
module tb_apb_req_arbiter;

  logic        clk;
  logic        reset_b;
  logic [1:0]  req;
  logic [1:0]  req_write;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  done;
  logic        err;
  logic [7:0]  rdata;
  logic        busy;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  paddr;
  logic [7:0]  pwdata;
  logic        pready;
  logic [7:0]  prdata;

  logic        slv_en;
  int          wait_need;
  int          acc_cnt;
  int          n_vec;
  int          n_err;
  int          n_acc;

  apb_req_arbiter #(
    .PADDR_WL (4),
    .PDATA_WL (8),
    .TIMEOUT  (15)
  ) dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .busy      (busy),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pready    (pready),
    .prdata    (prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: counts ACCESS cycles already elapsed in the current transfer.
  always @(posedge clk) begin
    if (psel && penable) begin
      acc_cnt <= acc_cnt + 1;
    end else begin
      acc_cnt <= 0;
    end
  end

  assign pready = slv_en & psel & penable & (acc_cnt >= wait_need);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    acc_cnt   = 0;
    slv_en    = 1'b1;
    wait_need = 0;
    reset_b   = 1'b0;
    req       = 2'b00;
    req_write = 2'b00;
    req_addr  = 8'h00;
    req_wdata = 16'h0000;
    prdata    = 8'h00;

    // Reset state
    #2;
    chk("rst_psel",    32'(psel),    32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite",  32'(pwrite),  32'd0);
    chk("rst_paddr",   32'(paddr),   32'd0);
    chk("rst_pwdata",  32'(pwdata),  32'd0);
    chk("rst_rdata",   32'(rdata),   32'd0);
    chk("rst_done",    32'(done),    32'd0);
    chk("rst_err",     32'(err),     32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    tick();
    reset_b = 1'b1;
    tick();

    // Requester 0 writes 0xA5 to address 3, immediate pready
    req       = 2'b01;
    req_write = 2'b01;
    req_addr  = 8'h03;
    req_wdata = 16'h00A5;
    tick();
    chk("wr_setup_psel",    32'(psel),    32'd1);
    chk("wr_setup_penable", 32'(penable), 32'd0);
    chk("wr_setup_pwrite",  32'(pwrite),  32'd1);
    chk("wr_setup_paddr",   32'(paddr),   32'd3);
    chk("wr_setup_pwdata",  32'(pwdata),  32'hA5);
    chk("wr_setup_busy",    32'(busy),    32'd1);
    req       = 2'b00;
    req_addr  = 8'hFF;
    req_wdata = 16'hFFFF;
    tick();
    chk("wr_access_psel",    32'(psel),    32'd1);
    chk("wr_access_penable", 32'(penable), 32'd1);
    chk("wr_access_paddr",   32'(paddr),   32'd3);
    chk("wr_access_done",    32'(done),    32'd0);
    tick();
    chk("wr_done_done",  32'(done),    32'd1);
    chk("wr_done_err",   32'(err),     32'd0);
    chk("wr_done_psel",  32'(psel),    32'd0);
    chk("wr_done_pen",   32'(penable), 32'd0);
    chk("wr_done_busy",  32'(busy),    32'd1);
    chk("wr_done_rdata", 32'(rdata),   32'd0);
    tick();
    chk("wr_idle_done",  32'(done),   32'd0);
    chk("wr_idle_busy",  32'(busy),   32'd0);
    chk("wr_idle_paddr", 32'(paddr),  32'd3);
    chk("wr_idle_pwrite",32'(pwrite), 32'd1);

    // Fresh reset, then both requesters hold req: grants 0,1,0,1
    reset_b = 1'b0;
    tick();
    reset_b   = 1'b1;
    req       = 2'b11;
    req_write = 2'b00;
    req_addr  = 8'h91;
    prdata    = 8'h11;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_paddr", 32'(paddr), (k % 2 == 0) ? 32'd1 : 32'd9);
      tick();
      tick();
      chk("rr_done",  32'(done),  (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_rdata", 32'(rdata), 32'h11);
      tick();
      chk("rr_idle_done", 32'(done), 32'd0);
    end
    req = 2'b00;
    tick();

    // Requester 1 reads address 5, slave inserts 2 wait cycles
    req       = 2'b10;
    req_write = 2'b00;
    req_addr  = 8'h50;
    prdata    = 8'h3C;
    wait_need = 2;
    tick();
    chk("rd_setup_paddr",  32'(paddr),  32'd5);
    chk("rd_setup_pwrite", 32'(pwrite), 32'd0);
    req = 2'b00;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rd_wait_penable", 32'(penable), 32'd1);
      chk("rd_wait_done",    32'(done),    32'd0);
    end
    tick();
    chk("rd_done_done",  32'(done),  32'd2);
    chk("rd_done_rdata", 32'(rdata), 32'h3C);
    chk("rd_done_err",   32'(err),   32'd0);
    tick();
    wait_need = 0;

    // pready tied low: abort after exactly 15 ACCESS cycles
    slv_en    = 1'b0;
    req       = 2'b01;
    req_addr  = 8'h07;
    prdata    = 8'hEE;
    tick();
    req = 2'b00;
    tick();
    n_acc = 0;
    while (penable === 1'b1 && n_acc < 40) begin
      n_acc++;
      tick();
    end
    chk("to_access_cycles", 32'(n_acc), 32'd15);
    chk("to_done",          32'(done),  32'd1);
    chk("to_err",           32'(err),   32'd1);
    chk("to_rdata",         32'(rdata), 32'h3C);
    tick();
    chk("to_idle_err",  32'(err),  32'd0);
    chk("to_idle_busy", 32'(busy), 32'd0);

    // Reset in the middle of ACCESS aborts without done
    req      = 2'b10;
    req_addr = 8'hA0;
    tick();
    req = 2'b00;
    tick();
    chk("mid_access_pen", 32'(penable), 32'd1);
    #2;
    reset_b = 1'b0;
    #1;
    chk("mid_rst_psel",  32'(psel),    32'd0);
    chk("mid_rst_pen",   32'(penable), 32'd0);
    chk("mid_rst_busy",  32'(busy),    32'd0);
    chk("mid_rst_paddr", 32'(paddr),   32'd0);
    tick();
    chk("mid_rst_done",  32'(done), 32'd0);
    reset_b   = 1'b1;
    slv_en    = 1'b1;
    req       = 2'b11;
    req_write = 2'b10;
    req_addr  = 8'hB2;
    req_wdata = 16'h7766;
    tick();
    chk("post_rst_paddr",  32'(paddr),  32'd2);
    chk("post_rst_pwrite", 32'(pwrite), 32'd0);
    req = 2'b00;
    tick();
    tick();
    chk("post_rst_done", 32'(done), 32'd1);
    chk("post_rst_err",  32'(err),  32'd0);
    tick();
    chk("post_rst_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 The module SHALL have parameter PADDR_WL, default 4, meaning APB address width in bits.
REQ-002 The module SHALL have parameter PDATA_WL, default 8, meaning APB data width in bits.
REQ-003 The module SHALL have parameter TIMEOUT, default 15, meaning maximum ACCESS cycles without pready before abort (range 1..255).
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 reset_b  input  1  asynchronous active-low reset.
REQ-006 req  input  2  per-requester level request; bit i for requester i.
REQ-007 req_write  input  2  per-requester transfer direction (1 = write).
REQ-008 req_addr  input  2*PADDR_WL  per-requester address; requester i uses bits [i*PADDR_WL +: PADDR_WL].
REQ-009 req_wdata  input  2*PDATA_WL  per-requester write data; requester i uses bits [i*PDATA_WL +: PDATA_WL].
REQ-010 done  output  2  one-cycle completion pulse to the granted requester.
REQ-011 err  output  1  high together with done when the transfer was aborted by timeout.
REQ-012 rdata  output  PDATA_WL  read data of the last successful read.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 psel, penable, pwrite  output  1 each  APB control to the slave.
REQ-015 paddr  output  PADDR_WL  APB address; pwdata  output  PDATA_WL  APB write data.
REQ-016 pready  input  1  and prdata  input  PDATA_WL: APB slave response.

Function
REQ-017 The module SHALL implement a four-state FSM: IDLE, SETUP, ACCESS, DONE; all outputs SHALL be registered.
REQ-018 In IDLE with any req bit high, the module SHALL grant one requester, latch its req_write/req_addr/req_wdata into pwrite/paddr/pwdata, and go to SETUP.
REQ-019 Arbitration SHALL be round-robin: with both requesting, the requester not granted last wins; with one requesting, it wins unconditionally.
REQ-020 In SETUP the module SHALL drive psel=1, penable=0 for exactly one cycle, then go to ACCESS.
REQ-021 In ACCESS the module SHALL drive psel=1, penable=1 and sample pready each cycle.
REQ-022 On pready=1 in ACCESS, the module SHALL capture prdata into rdata if pwrite=0 (rdata unchanged on writes), update the last-granted pointer, and go to DONE.
REQ-023 An ACCESS wait counter SHALL clear on entry to ACCESS; if pready stays low for TIMEOUT consecutive ACCESS cycles, the module SHALL go to DONE with err set, rdata unchanged, pointer updated.
REQ-024 In DONE the module SHALL drive psel=penable=0, assert done[granted]=1 for exactly one cycle, assert err only for a timed-out transfer, and return to IDLE.
REQ-025 Latency: req sampled high in IDLE at edge N -> psel at N+1, penable at N+2, done at N+3 when pready is immediate.
REQ-026 req, req_addr, req_wdata, req_write changes after grant SHALL be ignored until DONE; a requester dropping req mid-transfer SHALL still receive done.
REQ-027 A requester SHALL be considered to hold req until it sees done; a req still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-028 paddr/pwdata/pwrite SHALL hold their last values outside SETUP/ACCESS.

Reset
REQ-029 On reset_b=0 the module SHALL immediately enter IDLE and drive psel=penable=pwrite=0, paddr=0, pwdata=0, rdata=0, done=0, err=0, busy=0, wait counter=0.
REQ-030 Reset SHALL set the last-granted pointer to requester 1 so requester 0 wins the first simultaneous request.
REQ-031 Reset asserted mid-transfer SHALL abort it with no done pulse.

Verification
REQ-032 Requester 0 write addr 3 data 0xA5, pready=psel&&penable -> psel at N+1, penable at N+2, done=2'b01 at N+3, err=0, 3 busy cycles.
REQ-033 Both request after reset (req=2'b11, held) -> grants 0,1,0,1 in sequence, each with one done pulse.
REQ-034 Requester 1 read addr 5, slave returns 0x3C after 2 wait cycles -> rdata=0x3C in DONE cycle, done=2'b10.
REQ-035 pready tied low, TIMEOUT=15 -> exactly 15 ACCESS cycles, then done with err=1, rdata unchanged.
REQ-036 reset_b pulsed low during ACCESS -> psel/penable/busy 0 immediately, no done; next request served normally with requester 0 priority.
